// File: rtl/byte_serializer_pkg.sv
// Shared defaults and engine state encoding for the byte serializer and its hold register.
package byte_serializer_pkg;

    localparam int unsigned DefaultWidth     = 8;
    localparam bit          DefaultMsbFirst  = 1'b1;
    localparam logic        DefaultIdleLevel = 1'b0;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } eng_state_e;

endpackage

// File: rtl/byte_hold_reg.sv
// One-entry hold register that lets the next byte be taken while the current one shifts.
module byte_hold_reg
    import byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic             hold_valid_o,
    output logic [WIDTH-1:0] hold_data_o,
    output logic             ready_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Write and pop never coincide: writes are only possible while the entry is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (wr_en_i) begin
            valid_q <= 1'b1;
            data_q  <= wr_data_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign hold_valid_o = valid_q;
    assign hold_data_o  = data_q;
    assign ready_o      = ~valid_q;

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial front end: valid/ready byte input, one registered bit per clock out,
// with a fixed idle level whenever no byte is being shifted.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = DefaultWidth,
    parameter bit          MSB_FIRST  = DefaultMsbFirst,
    parameter logic        IDLE_LEVEL = DefaultIdleLevel
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             DATA_VALID,
    input  logic [WIDTH-1:0] DATA_BYTE,
    output logic             DATA_READY,
    output logic             DATA_OUT,
    output logic             BIT_VALID,
    output logic             BYTE_START
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);
    localparam int unsigned     OutIdx  = MSB_FIRST ? WIDTH - 1 : 0;

    eng_state_e       state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_shift;
    logic [CntW-1:0]  cnt_q;
    logic             data_out_q;
    logic             byte_start_q;

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             hold_ready;

    logic             accept;
    logic             load_slot;
    logic             do_load;
    logic             hold_pop;
    logic             hold_wr;
    logic [WIDTH-1:0] load_byte;

    assign accept    = DATA_VALID && hold_ready;
    // The last bit of a byte and an idle cycle are both opportunities to start a new byte.
    assign load_slot = (state_q == StIdle) || (cnt_q == '0);
    assign hold_pop  = load_slot && hold_valid;
    assign do_load   = load_slot && (hold_valid || accept);
    // A byte bypasses the hold only when it can be loaded straight into an empty slot.
    assign hold_wr   = accept && !(load_slot && !hold_valid);
    assign load_byte = hold_valid ? hold_data : DATA_BYTE;

    always_comb begin
        sreg_shift = sreg_q;
        if (MSB_FIRST) begin
            sreg_shift = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shift = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sreg_q       <= '0;
            cnt_q        <= '0;
            data_out_q   <= IDLE_LEVEL;
            byte_start_q <= 1'b0;
        end else if (do_load) begin
            state_q      <= StShift;
            sreg_q       <= load_byte;
            cnt_q        <= CntLoad;
            data_out_q   <= load_byte[OutIdx];
            byte_start_q <= 1'b1;
        end else if (load_slot) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            data_out_q   <= IDLE_LEVEL;
            byte_start_q <= 1'b0;
        end else begin
            state_q      <= StShift;
            sreg_q       <= sreg_shift;
            cnt_q        <= cnt_q - CntW'(1);
            data_out_q   <= sreg_shift[OutIdx];
            byte_start_q <= 1'b0;
        end
    end

    byte_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (hold_wr),
        .wr_data_i   (DATA_BYTE),
        .pop_i       (hold_pop),
        .hold_valid_o(hold_valid),
        .hold_data_o (hold_data),
        .ready_o     (hold_ready)
    );

    assign DATA_READY = hold_ready;
    assign DATA_OUT   = data_out_q;
    assign BIT_VALID  = (state_q == StShift);
    assign BYTE_START = byte_start_q;

endmodule
